// File: rtl/apb_master.sv
// apb_master: queued command front-end driving a single APB3 requester.
// Commands enter a small FIFO; a 3-state FSM replays them as APB transfers.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command push handshake (ready while queue not full)
//   cmd_write/addr/   command direction, address, write data
//   cmd_wdata
//   PSEL..PWDATA      registered APB requester outputs
//   PRDATA            slave read data, sampled at the end of ACCESS
//   rsp_valid/write/  one-cycle completion pulse with direction and
//   rsp_rdata         read data (0 for writes)
//   busy              FSM active or commands still queued
module apb_master #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [AMBA_ADDR_DEPTH:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]     cmd_wdata,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AMBA_ADDR_DEPTH:0] PADDR,
  output logic [AMBA_WORD-1:0]     PWDATA,
  input  logic [AMBA_WORD-1:0]     PRDATA,
  output logic                     rsp_valid,
  output logic                     rsp_write,
  output logic [AMBA_WORD-1:0]     rsp_rdata,
  output logic                     busy
);

  localparam int AW = AMBA_ADDR_DEPTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                 write;
    logic [AW-1:0]        addr;
    logic [AMBA_WORD-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          q_empty;
  state_t        state;
  state_t        state_n;

  assign q_empty   = (count == '0);
  assign cmd_ready = (count != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || !q_empty;

  // Storage carries no reset; only slots between rd_ptr and
  // wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        write: cmd_write,
        addr:  cmd_addr,
        wdata: cmd_wdata
      };
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Pops happen only from IDLE or ACCESS so ACCESS can chain
  // straight into the next SETUP without an idle gap.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = ACCESS;
      end
      ACCESS: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // APB strobes are decoded from the next state so they come
  // straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      PSEL      <= (state_n != IDLE);
      PENABLE   <= (state_n == ACCESS);
      rsp_valid <= (state == ACCESS);
      if (state == ACCESS) begin
        rsp_write <= PWRITE;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end
      if (pop) begin
        PWRITE <= head.write;
        PADDR  <= head.addr;
        PWDATA <= head.write ? head.wdata : '0;
      end
    end
  end

endmodule
